// File: rtl/jam1_alu_pkg.sv
// jam1_alu_pkg
// Shared constants for the JAM-1 ALU datapath.
//   FLAG_* : bit positions inside the 4-bit {V,N,Z,C} flag vector
//   FLAG_W : flag vector width
//   DATA_W : ALU datapath width
//   FM_*   : common FlagMask presets used by the decoder
package jam1_alu_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam int FLAG_W = 4;
    localparam int DATA_W = 8;

    localparam logic [FLAG_W-1:0] FM_ALL  = 4'hF;
    localparam logic [FLAG_W-1:0] FM_ZN   = 4'h6;
    localparam logic [FLAG_W-1:0] FM_NONE = 4'h0;

    // Apply a per-bit update mask: masked bits take 'upd', others keep 'cur'.
    function automatic logic [FLAG_W-1:0] merge_flags(
        input logic [FLAG_W-1:0] cur,
        input logic [FLAG_W-1:0] upd,
        input logic [FLAG_W-1:0] mask
    );
        return (upd & mask) | (cur & ~mask);
    endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// alu_flag_calc
// Combinational flag derivation from a raw ALU result. Shared with the
// compare path, so it holds no state.
// Ports:
//   result_in   in  DATA_W  ALU result
//   carry_in    in  1       ALU carry out
//   overflow_in in  1       ALU signed overflow
//   flags_out   out FLAG_W  computed {V,N,Z,C}
module alu_flag_calc
    import jam1_alu_pkg::*;
(
    input  logic [DATA_W-1:0] result_in,
    input  logic              carry_in,
    input  logic              overflow_in,
    output logic [FLAG_W-1:0] flags_out
);

    always_comb begin
        flags_out         = '0;
        flags_out[FLAG_C] = carry_in;
        flags_out[FLAG_Z] = (result_in == '0);
        flags_out[FLAG_N] = result_in[DATA_W-1];
        flags_out[FLAG_V] = overflow_in;
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Execute-to-writeback register for the JAM-1 ALU. Captures the result,
// maintains the architectural flags with per-op update masks, a shadow copy
// for interrupt entry/exit, and stall/flush control.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   InValid/Stall/Flush   pipeline control from execute
//   ResultIn/CarryIn/OverflowIn  raw ALU outputs
//   FlagMask              per-flag update enable {V,N,Z,C}
//   FlagLoad/FlagLoadData POP F load path
//   FlagSave/FlagRestore  shadow copy (interrupt entry / RTI); both = swap
//   ResultOut/ResultValid registered result and commit indicator
//   Flags                 architectural flags {V,N,Z,C}
//   CarryFwd              registered C, fed back to the ALU carry input
// All outputs come straight from flops.
module alu_result_stage
    import jam1_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [WIDTH-1:0] ResultIn,
    input  logic             CarryIn,
    input  logic             OverflowIn,
    input  logic [3:0]       FlagMask,
    input  logic             FlagLoad,
    input  logic [3:0]       FlagLoadData,
    input  logic             FlagSave,
    input  logic             FlagRestore,
    output logic [WIDTH-1:0] ResultOut,
    output logic             ResultValid,
    output logic [3:0]       Flags,
    output logic             CarryFwd
);

    logic [WIDTH-1:0]  result_q,  result_d;
    logic              valid_q,   valid_d;
    logic [FLAG_W-1:0] flags_q,   flags_d;
    logic [FLAG_W-1:0] shadow_q,  shadow_d;
    logic [FLAG_W-1:0] calc_flags;

    alu_flag_calc u_flag_calc (
        .result_in   (ResultIn),
        .carry_in    (CarryIn),
        .overflow_in (OverflowIn),
        .flags_out   (calc_flags)
    );

    always_comb begin
        result_d = result_q;
        valid_d  = valid_q;
        flags_d  = flags_q;
        shadow_d = shadow_q;

        if (Flush) begin
            // Squash: only the valid bit drops; result and flag state hold,
            // and flag controls riding on the squashed op are discarded.
            valid_d = 1'b0;
        end else if (!Stall) begin
            valid_d = InValid;
            if (InValid) begin
                result_d = ResultIn;
            end

            if (FlagRestore) begin
                flags_d = shadow_q;
            end else if (FlagLoad) begin
                flags_d = FlagLoadData;
            end else if (InValid) begin
                flags_d = merge_flags(flags_q, calc_flags, FlagMask);
            end

            // Save takes the pre-edge flags, so Save+Restore is a swap.
            if (FlagSave) begin
                shadow_d = flags_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            flags_q  <= '0;
            shadow_q <= '0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
        end
    end

    assign ResultOut   = result_q;
    assign ResultValid = valid_q;
    assign Flags       = flags_q;
    assign CarryFwd    = flags_q[FLAG_C];

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       reset, InValid, Stall, Flush;
    logic [7:0] ResultIn;
    logic       CarryIn, OverflowIn;
    logic [3:0] FlagMask;
    logic       FlagLoad;
    logic [3:0] FlagLoadData;
    logic       FlagSave, FlagRestore;
    logic [7:0] ResultOut;
    logic       ResultValid;
    logic [3:0] Flags;
    logic       CarryFwd;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    logic [7:0] m_res;
    logic       m_vld;
    logic [3:0] m_flags;
    logic [3:0] m_shadow;

    alu_result_stage #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .InValid      (InValid),
        .Stall        (Stall),
        .Flush        (Flush),
        .ResultIn     (ResultIn),
        .CarryIn      (CarryIn),
        .OverflowIn   (OverflowIn),
        .FlagMask     (FlagMask),
        .FlagLoad     (FlagLoad),
        .FlagLoadData (FlagLoadData),
        .FlagSave     (FlagSave),
        .FlagRestore  (FlagRestore),
        .ResultOut    (ResultOut),
        .ResultValid  (ResultValid),
        .Flags        (Flags),
        .CarryFwd     (CarryFwd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, advance the model, check after edge.
    task automatic apply(
        input logic       rst, inv, stl, fl,
        input logic [7:0] ri,
        input logic       ci, oi,
        input logic [3:0] fm,
        input logic       fld,
        input logic [3:0] fldd,
        input logic       fs, fr
    );
        logic [3:0] calc, old_flags;
        @(negedge clk);
        reset = rst; InValid = inv; Stall = stl; Flush = fl;
        ResultIn = ri; CarryIn = ci; OverflowIn = oi; FlagMask = fm;
        FlagLoad = fld; FlagLoadData = fldd; FlagSave = fs; FlagRestore = fr;

        calc = {oi, (ri >= 8'd128), (ri == 8'd0), ci};
        old_flags = m_flags;
        if (rst) begin
            m_res = 0; m_vld = 0; m_flags = 0; m_shadow = 0;
        end else if (fl) begin
            m_vld = 0;
        end else if (!stl) begin
            m_vld = inv;
            if (inv) m_res = ri;
            if (fr)       m_flags = m_shadow;
            else if (fld) m_flags = fldd;
            else if (inv)
                for (int i = 0; i < 4; i++)
                    if (fm[i]) m_flags[i] = calc[i];
            if (fs) m_shadow = old_flags;
        end

        @(posedge clk);
        #1;
        chk("ResultOut",   ResultOut,   m_res);
        chk("ResultValid", ResultValid, m_vld);
        chk("Flags",       Flags,       m_flags);
        chk("CarryFwd",    CarryFwd,    m_flags[0]);
    endtask

    // Normal valid op helper
    task automatic op(input logic [7:0] ri, input logic ci, input logic oi, input logic [3:0] fm);
        apply(0, 1, 0, 0, ri, ci, oi, fm, 0, 4'h0, 0, 0);
    endtask

    task automatic load(input logic [3:0] d, input logic fs);
        apply(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 1, d, fs, 0);
    endtask

    initial begin
        m_res = 0; m_vld = 0; m_flags = 0; m_shadow = 0;

        // Reset
        apply(1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 0);
        apply(1, 1, 0, 0, 8'hFF, 1, 1, 4'hF, 1, 4'hF, 1, 1);
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_valid", ResultValid, 1'b0);

        // Zero result with carry, all flags updated
        op(8'h00, 1, 0, 4'hF);
        chk("tp1_flags", Flags, 4'b0011);
        chk("tp1_cfwd", CarryFwd, 1'b1);

        // Z/N-only mask preserves C and V
        load(4'b1001, 0);
        op(8'h80, 0, 0, 4'h6);
        chk("tp2_flags", Flags, 4'b1101);

        // Stall three cycles, commit on release
        for (int i = 0; i < 3; i++)
            apply(0, 1, 1, 0, 8'h5A, 1, 1, 4'hF, 0, 4'h0, 0, 0);
        chk("stall_hold", ResultOut, 8'h80);
        op(8'h5A, 1, 1, 4'hF);
        chk("stall_rel", ResultOut, 8'h5A);
        chk("stall_flags", Flags, 4'b1001);

        // Flush beats stall and discards the flag load
        apply(0, 1, 1, 1, 8'h33, 0, 0, 4'hF, 1, 4'h6, 1, 1);
        chk("flush_valid", ResultValid, 1'b0);
        chk("flush_res", ResultOut, 8'h5A);

        // Save/restore swap, then restore alone to expose the shadow
        load(4'b1010, 0);
        load(4'b0001, 1);                       // shadow <- 1010
        apply(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 1, 1);
        chk("swap_flags", Flags, 4'b1010);
        apply(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 1);
        chk("swap_shadow", Flags, 4'b0001);

        // Restore has priority over load on a bubble
        apply(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 1, 4'hC, 0, 1);

        // Reset after a valid op, with a load pending
        op(8'h7F, 1, 1, 4'hF);
        apply(1, 1, 0, 0, 8'h44, 1, 1, 4'hF, 1, 4'hF, 0, 0);
        chk("rst2_res", ResultOut, 8'h00);
        chk("rst2_flags", Flags, 4'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] fm;
            case ($urandom_range(0, 3))
                0: fm = 4'hF;
                1: fm = 4'h6;
                2: fm = 4'h0;
                default: fm = 4'($urandom);
            endcase
            apply($urandom_range(0, 31) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                  1'($urandom), 1'($urandom), fm,
                  $urandom_range(0, 7) == 0, 4'($urandom),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
